// File: rtl/fetch_pkg.sv
// Shared encodings and widths for the instruction fetch port.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_HI = 2'd1,
    RD_LO = 2'd2
  } fetch_state_e;

  localparam int LINE_W = 32;
  localparam int HALF_W = 16;

  localparam logic [1:0] OFS_HI = 2'b00;
  localparam logic [1:0] OFS_LO = 2'b10;

endpackage

// File: rtl/fetch_port.sv
// Instruction fetch responder: one 32-bit line buffer refilled from a
// 16-bit handshaked memory bus in two beats (high halfword first).
module fetch_port
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        pc_in,
  input  logic                     fetch_en,
  input  logic                     flush,
  output logic [LINE_W-1:0]        fetch_opc,
  output logic                     hold,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  input  logic                     mem_ack,
  input  logic [HALF_W-1:0]        mem_rdata
);

  fetch_state_e            state_q;
  logic                    tag_valid_q;
  logic [ADDR_W-3:0]       tag_q;
  logic [ADDR_W-3:0]       req_tag_q;
  logic [LINE_W-1:0]       line_q;
  logic                    discard_q;
  logic                    mem_rd_q;
  logic [ADDR_W-1:0]       mem_addr_q;

  logic                    hit;
  logic                    beat_done;

  assign hit       = tag_valid_q & (tag_q == pc_in[ADDR_W-1:2]);
  assign beat_done = mem_rd_q & mem_ack;
  assign hold      = fetch_en & ~(hit & (state_q == IDLE));
  assign fetch_opc = line_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;

  // Fill FSM; bus outputs only move on a completed beat so the request stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_valid_q <= 1'b0;
      tag_q       <= {(ADDR_W-2){1'b0}};
      req_tag_q   <= {(ADDR_W-2){1'b0}};
      line_q      <= {LINE_W{1'b0}};
      discard_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            tag_valid_q <= 1'b0;
          end
          if (fetch_en && !hit) begin
            req_tag_q  <= pc_in[ADDR_W-1:2];
            mem_addr_q <= {pc_in[ADDR_W-1:2], OFS_HI};
            mem_rd_q   <= 1'b1;
            state_q    <= RD_HI;
          end
        end
        RD_HI: begin
          if (flush) begin
            discard_q <= 1'b1;
          end
          if (beat_done) begin
            line_q[LINE_W-1:HALF_W] <= mem_rdata;
            mem_addr_q              <= {req_tag_q, OFS_LO};
            state_q                 <= RD_LO;
          end
        end
        RD_LO: begin
          // A flush racing the final beat still invalidates the line being written.
          if (beat_done) begin
            line_q[HALF_W-1:0] <= mem_rdata;
            mem_rd_q           <= 1'b0;
            tag_q              <= req_tag_q;
            tag_valid_q        <= ~discard_q & ~flush;
            discard_q          <= 1'b0;
            state_q            <= IDLE;
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
